fifo_level: RTL and testbench

Parametrised synchronous FIFO with an occupancy counter, programmable almost-full/almost-empty thresholds and a synchronous flush. Simultaneous read and write are handled correctly at the full and empty boundaries. Optional sticky overflow/underflow error flags can be compiled in. It is the general-purpose buffer between the UART receive/transmit paths and the morse encode/decode logic, where it replaces the plain circular-buffer FIFO.

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_mem.sv | 39 +++
 rtl/fifo_level.sv | 157 +++++++++++++++
 tb/tb_fifo_level.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the fifo_level buffer:
//   fifo_depth()      - number of entries for a given address width
//   fifo_count_bits() - width of the occupancy counter (ADDR_BITS+1)
//   fifo_params_ok()  - parameter legality test, used to stop elaboration
//                       when a threshold or width is out of range
// -----------------------------------------------------------------------------
package fifo_pkg;

    function automatic int unsigned fifo_depth(input int unsigned addr_bits);
        return 32'd1 << addr_bits;
    endfunction

    function automatic int unsigned fifo_count_bits(input int unsigned addr_bits);
        return addr_bits + 32'd1;
    endfunction

    function automatic bit fifo_params_ok(input int unsigned word_bits,
                                          input int unsigned addr_bits,
                                          input int unsigned afull_lvl,
                                          input int unsigned aempty_lvl);
        int unsigned depth;
        depth = fifo_depth(addr_bits);
        return (word_bits >= 1) && (addr_bits >= 1) &&
               (afull_lvl <= depth) && (aempty_lvl <= depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Storage array for fifo_level: one synchronous write port, one asynchronous
// read port, WORD_BITS x 2**ADDR_BITS, no reset (contents survive reset).
// Ports:
//   clk_i    - clock (rising edge)
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data, combinational from raddr_i
// -----------------------------------------------------------------------------
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned WORD_BITS = 8,
    parameter int unsigned ADDR_BITS = 4
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [WORD_BITS-1:0] wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [WORD_BITS-1:0] rdata_o
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_BITS);

    logic [WORD_BITS-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_level.sv
// -----------------------------------------------------------------------------
// fifo_level
// Synchronous first-word-fall-through FIFO with occupancy counter,
// programmable almost-full / almost-empty thresholds and synchronous flush.
// Optional sticky overflow/underflow flags are built when the macro
// FIFO_LEVEL_ERR_FLAGS_EN is defined; otherwise both outputs are tied low.
// Ports:
//   clk_i          - clock, rising edge
//   reset_n_i      - synchronous active-low reset
//   clear_i        - synchronous flush (empties FIFO, clears error flags)
//   read_i         - pop head entry
//   write_i        - push wdata_i
//   wdata_i        - write data
//   rdata_o        - head entry (don't-care while empty)
//   empty_o/full_o - count == 0 / count == DEPTH
//   almost_empty_o - count <= AEMPTY_LVL
//   almost_full_o  - count >= AFULL_LVL
//   count_o        - occupancy, 0..DEPTH
//   overflow_o     - sticky: write rejected
//   underflow_o    - sticky: read rejected
// -----------------------------------------------------------------------------
module fifo_level
    import fifo_pkg::*;
#(
    parameter int unsigned WORD_BITS  = 8,
    parameter int unsigned ADDR_BITS  = 4,
    parameter int unsigned AFULL_LVL  = (32'd1 << ADDR_BITS) - 32'd2,
    parameter int unsigned AEMPTY_LVL = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 clear_i,
    input  logic                 read_i,
    input  logic                 write_i,
    input  logic [WORD_BITS-1:0] wdata_i,
    output logic [WORD_BITS-1:0] rdata_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic                 almost_empty_o,
    output logic                 almost_full_o,
    output logic [ADDR_BITS:0]   count_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    localparam int unsigned DEPTH      = fifo_depth(ADDR_BITS);
    localparam int unsigned COUNT_BITS = fifo_count_bits(ADDR_BITS);

    if (!fifo_params_ok(WORD_BITS, ADDR_BITS, AFULL_LVL, AEMPTY_LVL)) begin : g_bad_params
        $error("fifo_level: illegal parameters (WORD_BITS/ADDR_BITS >= 1, thresholds <= DEPTH)");
    end

    localparam logic [COUNT_BITS-1:0] DEPTH_C  = COUNT_BITS'(DEPTH);
    localparam logic [COUNT_BITS-1:0] AFULL_C  = COUNT_BITS'(AFULL_LVL);
    localparam logic [COUNT_BITS-1:0] AEMPTY_C = COUNT_BITS'(AEMPTY_LVL);

    logic [ADDR_BITS-1:0]  wptr_q, wptr_d;
    logic [ADDR_BITS-1:0]  rptr_q, rptr_d;
    logic [COUNT_BITS-1:0] count_q, count_d;

    logic full;
    logic empty;
    logic rd_acc;
    logic wr_acc;
    logic mem_we;

    // All flags come from the registered count; pointers are never compared.
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // A read frees a slot in the same cycle, so a full FIFO still accepts a
    // write alongside a read. An empty FIFO has nothing to pop.
    assign rd_acc = read_i & ~empty;
    assign wr_acc = write_i & (~full | read_i);

    // Writes are discarded during reset and flush.
    assign mem_we = wr_acc & ~clear_i & reset_n_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            wptr_d  = wptr_q + ADDR_BITS'(wr_acc);
            rptr_d  = rptr_q + ADDR_BITS'(rd_acc);
            count_d = count_q + COUNT_BITS'(wr_acc) - COUNT_BITS'(rd_acc);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

`ifdef FIFO_LEVEL_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (write_i & full & ~read_i) overflow_d  = 1'b1;
            if (read_i & empty)           underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

    fifo_mem #(
        .WORD_BITS (WORD_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (wptr_q),
        .wdata_i (wdata_i),
        .raddr_i (rptr_q),
        .rdata_o (rdata_o)
    );

    assign count_o        = count_q;
    assign empty_o        = empty;
    assign full_o         = full;
    assign almost_empty_o = (count_q <= AEMPTY_C);
    assign almost_full_o  = (count_q >= AFULL_C);

endmodule

// File: tb/tb_fifo_level.sv
// -----------------------------------------------------------------------------
// tb_fifo_level
// Self-checking bench for fifo_level (default 8-bit x 16-deep). A queue holds
// the expected contents and sticky flags; every cycle all outputs are compared
// against it on the falling edge. Directed scenarios are followed by a
// randomized phase with alternating fill/drain bias.
// -----------------------------------------------------------------------------
module tb_fifo_level;

    localparam int unsigned WB     = 8;
    localparam int unsigned AB     = 4;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AFULL  = 14;
    localparam int unsigned AEMPTY = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear = 1'b0;
    logic          rd = 1'b0;
    logic          wr = 1'b0;
    logic [WB-1:0] wdata = '0;
    logic [WB-1:0] rdata;
    logic          empty, full, aempty, afull, ovf, udf;
    logic [AB:0]   count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [WB-1:0] q [$];
    bit            ovf_m = 1'b0;
    bit            udf_m = 1'b0;

    always #5 clk = ~clk;

    fifo_level #(
        .WORD_BITS  (WB),
        .ADDR_BITS  (AB),
        .AFULL_LVL  (AFULL),
        .AEMPTY_LVL (AEMPTY)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .clear_i        (clear),
        .read_i         (rd),
        .write_i        (wr),
        .wdata_i        (wdata),
        .rdata_o        (rdata),
        .empty_o        (empty),
        .full_o         (full),
        .almost_empty_o (aempty),
        .almost_full_o  (afull),
        .count_o        (count),
        .overflow_o     (ovf),
        .underflow_o    (udf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Compare every output against the queue model.
    task automatic check_all(input string tag);
        int unsigned n;
        n = q.size();
        check({tag, ".count"},  32'(count),  32'(n));
        check({tag, ".empty"},  32'(empty),  32'(n == 0));
        check({tag, ".full"},   32'(full),   32'(n == DEPTH));
        check({tag, ".aempty"}, 32'(aempty), 32'(n <= AEMPTY));
        check({tag, ".afull"},  32'(afull),  32'(n >= AFULL));
        check({tag, ".ovf"},    32'(ovf),    32'(ovf_m));
        check({tag, ".udf"},    32'(udf),    32'(udf_m));
        if (n != 0) check({tag, ".rdata"}, 32'(rdata), 32'(q[0]));
    endtask

    // Apply one cycle of stimulus, advance the model, check on the falling edge.
    task automatic step(input string tag, input bit w, input bit r,
                        input logic [WB-1:0] d, input bit clr, input bit rst_n);
        int unsigned n;
        wr      = w;
        rd      = r;
        wdata   = d;
        clear   = clr;
        reset_n = rst_n;
        @(posedge clk);
        n = q.size();
        if (!rst_n) begin
            q.delete();
            ovf_m = 1'b0;
            udf_m = 1'b0;
        end else if (clr) begin
            q.delete();
            ovf_m = 1'b0;
            udf_m = 1'b0;
        end else begin
`ifdef FIFO_LEVEL_ERR_FLAGS_EN
            if (w && n == DEPTH && !r) ovf_m = 1'b1;
            if (r && n == 0)           udf_m = 1'b1;
`endif
            if (r && n > 0) void'(q.pop_front());
            if (w && (n < DEPTH || r)) q.push_back(d);
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        logic [WB-1:0] seen;
        int unsigned   wbias;

        // Reset
        @(negedge clk);
        step("reset", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        step("reset", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("reset.afull_const", 32'(afull), 32'd0);
        check("reset.empty_const", 32'(empty), 32'd1);

        // Fill with 0x11..0x1F, then 0x20 to reach full
        for (int i = 0; i < 15; i++) begin
            step("fill", 1'b1, 1'b0, 8'(8'h11 + i), 1'b0, 1'b1);
            if (i == 12) check("fill.afull_at13", 32'(afull), 32'd0);
            if (i == 13) check("fill.afull_at14", 32'(afull), 32'd1);
        end
        check("fill.count15", 32'(count), 32'd15);
        check("fill.notfull", 32'(full), 32'd0);
        step("fill16", 1'b1, 1'b0, 8'h20, 1'b0, 1'b1);
        check("fill.full", 32'(full), 32'd1);
        check("fill.count16", 32'(count), 32'd16);

        // Simultaneous read/write while full
        step("full_rw", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
        check("full_rw.rdata", 32'(rdata), 32'h12);
        check("full_rw.count", 32'(count), 32'd16);
        check("full_rw.ovf", 32'(ovf), 32'd0);

        // Drain all 16; last word seen must be 0xAA
        seen = '0;
        for (int i = 0; i < 16; i++) begin
            seen = rdata;
            step("drain", 1'b0, 1'b1, '0, 1'b0, 1'b1);
        end
        check("drain.last", 32'(seen), 32'hAA);
        check("drain.empty", 32'(empty), 32'd1);

        // Simultaneous read/write while empty: only the write lands
        step("empty_rw", 1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
        check("empty_rw.count", 32'(count), 32'd1);
        check("empty_rw.rdata", 32'(rdata), 32'h55);
`ifdef FIFO_LEVEL_ERR_FLAGS_EN
        check("empty_rw.udf", 32'(udf), 32'd1);
`else
        check("empty_rw.udf", 32'(udf), 32'd0);
`endif

        // Overflow: 20 writes into 16 entries, sticky through reads, then flush
        step("clr", 1'b0, 1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step("ovf_fill", 1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)  step("ovf_read", 1'b0, 1'b1, '0, 1'b0, 1'b1);
`ifdef FIFO_LEVEL_ERR_FLAGS_EN
        check("ovf.sticky", 32'(ovf), 32'd1);
`else
        check("ovf.sticky", 32'(ovf), 32'd0);
`endif
        // Flush with a concurrent write: the write must be discarded
        step("ovf_clr", 1'b1, 1'b0, 8'hEE, 1'b1, 1'b1);
        check("ovf_clr.count", 32'(count), 32'd0);
        check("ovf_clr.ovf", 32'(ovf), 32'd0);
        check("ovf_clr.empty", 32'(empty), 32'd1);

        // Wrap-around: 40 write/read pairs
        for (int i = 0; i < 40; i++) begin
            step("wrap_w", 1'b1, 1'b0, 8'(8'h80 + i), 1'b0, 1'b1);
            check("wrap.rdata", 32'(rdata), 32'(8'(8'h80 + i)));
            step("wrap_r", 1'b0, 1'b1, '0, 1'b0, 1'b1);
        end

        // Reset mid-stream with count 9 and write asserted
        for (int i = 0; i < 9; i++) step("pre_rst", 1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, 1'b1);
        check("pre_rst.count", 32'(count), 32'd9);
        step("mid_rst", 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
        check("mid_rst.count", 32'(count), 32'd0);
        check("mid_rst.empty", 32'(empty), 32'd1);
        check("mid_rst.aempty", 32'(aempty), 32'd1);

        // Randomized traffic with alternating fill/drain bias
        for (int i = 0; i < 600; i++) begin
            wbias = ((i / 100) % 2 == 0) ? 75 : 25;
            step("rand",
                 $urandom_range(0, 99) < wbias,
                 $urandom_range(0, 99) >= wbias,
                 8'($urandom),
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 249) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
